// File: rtl/apb_pkg.sv
// Shared types and default sizing for the APB request bridge.
package apb_pkg;

  localparam int APB_ADDR_W         = 32;
  localparam int APB_DATA_W         = 32;
  localparam int APB_DEPTH          = 4;
  localparam int APB_TIMEOUT_CYCLES = 16;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } state_t;

  typedef struct packed {
    logic                  write;
    logic [APB_ADDR_W-1:0] addr;
    logic [APB_DATA_W-1:0] wdata;
  } apb_req_t;

endpackage

// File: rtl/apb_req_fifo.sv
// Synchronous request FIFO; DEPTH must be a power of two so the pointers wrap naturally.
// The entry type is a parameter so the bridge can store requests at its own widths.
module apb_req_fifo
  import apb_pkg::*;
#(
  parameter int  DEPTH = APB_DEPTH,
  parameter type T     = apb_req_t
) (
  input  logic PCLK,
  input  logic PRESET,
  input  logic push,
  input  T     push_data,
  input  logic pop,
  output T     pop_data,
  output logic full,
  output logic empty
);

  localparam int PW = $clog2(DEPTH);

  T              mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          do_push;
  logic          do_pop;

  // A push is refused when full even if a pop happens in the same cycle.
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign full     = (count == (PW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge PCLK) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/apb_req_bridge.sv
// APB requester: queues commands, runs SETUP->ACCESS transfers, returns responses.
// Define APB_TIMEOUT_EN to abort ACCESS phases that wait longer than TIMEOUT_CYCLES.
module apb_req_bridge
  import apb_pkg::*;
#(
  parameter int ADDR_W         = APB_ADDR_W,
  parameter int DATA_W         = APB_DATA_W,
  parameter int DEPTH          = APB_DEPTH,
  parameter int TIMEOUT_CYCLES = APB_TIMEOUT_CYCLES
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  state_t state, state_n;
  req_t   fifo_in, fifo_out;
  logic   fifo_full, fifo_empty, fifo_pop;

  logic              psel_n, penable_n, pwrite_n;
  logic [ADDR_W-1:0] paddr_n;
  logic [DATA_W-1:0] pwdata_n;
  logic              rsp_valid_n, rsp_err_n;
  logic [DATA_W-1:0] rsp_rdata_n;

`ifdef APB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt, tmo_n;
`endif

  assign fifo_in   = '{write: req_write, addr: req_addr, wdata: req_wdata};
  assign req_ready = !fifo_full;
  assign busy      = !fifo_empty || (state != IDLE);

  apb_req_fifo #(
    .DEPTH (DEPTH),
    .T     (req_t)
  ) u_fifo (
    .PCLK      (PCLK),
    .PRESET    (PRESET),
    .push      (req_valid),
    .push_data (fifo_in),
    .pop       (fifo_pop),
    .pop_data  (fifo_out),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state     <= IDLE;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
`ifdef APB_TIMEOUT_EN
      tmo_cnt   <= '0;
`endif
    end else begin
      state     <= state_n;
      PSEL      <= psel_n;
      PENABLE   <= penable_n;
      PWRITE    <= pwrite_n;
      PADDR     <= paddr_n;
      PWDATA    <= pwdata_n;
      rsp_valid <= rsp_valid_n;
      rsp_rdata <= rsp_rdata_n;
      rsp_err   <= rsp_err_n;
`ifdef APB_TIMEOUT_EN
      tmo_cnt   <= tmo_n;
`endif
    end
  end

  // APB outputs are registered, so each state computes the values seen in the next state.
  always_comb begin
    state_n     = state;
    psel_n      = PSEL;
    penable_n   = PENABLE;
    pwrite_n    = PWRITE;
    paddr_n     = PADDR;
    pwdata_n    = PWDATA;
    rsp_valid_n = rsp_valid;
    rsp_rdata_n = rsp_rdata;
    rsp_err_n   = rsp_err;
    fifo_pop    = 1'b0;
`ifdef APB_TIMEOUT_EN
    tmo_n       = tmo_cnt;
`endif
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          psel_n   = 1'b1;
          pwrite_n = fifo_out.write;
          paddr_n  = fifo_out.addr;
          pwdata_n = fifo_out.wdata;
          state_n  = SETUP;
        end
      end
      SETUP: begin
        penable_n = 1'b1;
        state_n   = ACCESS;
`ifdef APB_TIMEOUT_EN
        tmo_n     = '0;
`endif
      end
      ACCESS: begin
        if (PREADY) begin
          psel_n      = 1'b0;
          penable_n   = 1'b0;
          rsp_valid_n = 1'b1;
          rsp_rdata_n = PWRITE ? '0 : PRDATA;
          rsp_err_n   = PSLVERR;
          state_n     = RESP;
        end
`ifdef APB_TIMEOUT_EN
        else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          psel_n      = 1'b0;
          penable_n   = 1'b0;
          rsp_valid_n = 1'b1;
          rsp_rdata_n = '0;
          rsp_err_n   = 1'b1;
          state_n     = RESP;
        end else begin
          tmo_n = tmo_cnt + 1'b1;
        end
`endif
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_n = 1'b0;
          state_n     = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_apb_req_bridge.sv
// Directed self-checking bench for apb_req_bridge; the slave side is modelled inline.
module tb_apb_req_bridge;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err, busy;
  logic [31:0] rsp_rdata;
  logic        PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
  logic [31:0] PADDR, PWDATA, PRDATA;

  logic        prdata_auto;
  logic [31:0] prdata_drv;
  logic        slverr_on_write;

  int compared   = 0;
  int mismatched = 0;

  always #5 PCLK = ~PCLK;

  // Slave model: read data derived from the address, error optionally raised on writes.
  assign PRDATA  = prdata_auto ? (PADDR ^ 32'hA5A5_0000) : prdata_drv;
  assign PSLVERR = slverr_on_write & PWRITE & PSEL & PENABLE;

  apb_req_bridge #(
    .ADDR_W(32), .DATA_W(32), .DEPTH(4), .TIMEOUT_CYCLES(16)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .busy(busy),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic push_req(input logic w, input logic [31:0] a, input logic [31:0] d);
    int n;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    n = 0;
    while (!req_ready && n < 20) begin tick(); n++; end
    compared++;
    if (!req_ready) begin
      mismatched++;
      $display("[TB] FAIL push_timeout addr %h: req_ready got %b required 1", a, req_ready);
    end
    tick();
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    PRESET = 1'b1;
    tick(); tick();
    compared++;
    if ({PSEL, PENABLE, PWRITE, rsp_valid, rsp_err, busy, req_ready} !== 7'b0000001 ||
        PADDR !== 32'h0 || PWDATA !== 32'h0 || rsp_rdata !== 32'h0) begin
      mismatched++;
      $display("[TB] FAIL reset_state: ctl got %b required 0000001, paddr %h pwdata %h rdata %h required 0",
               {PSEL, PENABLE, PWRITE, rsp_valid, rsp_err, busy, req_ready}, PADDR, PWDATA, rsp_rdata);
    end
    PRESET = 1'b0;
    tick();
  endtask

  task automatic test_write_basic();
    PREADY = 1'b1; rsp_ready = 1'b0; prdata_auto = 1'b0; prdata_drv = 32'h1111_2222;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h1000; req_wdata = 32'hABCD_1234;
    tick();
    req_valid = 1'b0;
    compared++;
    if (PSEL !== 1'b0) begin
      mismatched++; $display("[TB] FAIL wr_e0_psel: got %b required 0", PSEL);
    end
    tick();
    compared++;
    if ({PSEL, PENABLE, PWRITE} !== 3'b101 || PADDR !== 32'h1000 || PWDATA !== 32'hABCD_1234) begin
      mismatched++;
      $display("[TB] FAIL wr_e1_setup: sel/en/wr got %b required 101, paddr %h required 00001000, pwdata %h required abcd1234",
               {PSEL, PENABLE, PWRITE}, PADDR, PWDATA);
    end
    tick();
    compared++;
    if ({PSEL, PENABLE, rsp_valid} !== 3'b110) begin
      mismatched++; $display("[TB] FAIL wr_e2_access: sel/en/rv got %b required 110", {PSEL, PENABLE, rsp_valid});
    end
    tick();
    compared++;
    if ({rsp_valid, PSEL, PENABLE, rsp_err} !== 4'b1000 || rsp_rdata !== 32'h0) begin
      mismatched++;
      $display("[TB] FAIL wr_e3_resp: rv/sel/en/err got %b required 1000, rdata %h required 0",
               {rsp_valid, PSEL, PENABLE, rsp_err}, rsp_rdata);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    compared++;
    if ({rsp_valid, busy} !== 2'b00) begin
      mismatched++; $display("[TB] FAIL wr_consume: rv/busy got %b required 00", {rsp_valid, busy});
    end
  endtask

  task automatic test_read_wait();
    PREADY = 1'b0; rsp_ready = 1'b0; prdata_auto = 1'b0; prdata_drv = 32'h0;
    push_req(1'b0, 32'h0000_0010, 32'h0);
    tick(); tick();
    for (int c = 0; c < 3; c++) begin
      compared++;
      if ({PSEL, PENABLE, rsp_valid} !== 3'b110 || PADDR !== 32'h10) begin
        mismatched++;
        $display("[TB] FAIL rd_access_cycle%0d: sel/en/rv got %b required 110, paddr %h required 00000010",
                 c, {PSEL, PENABLE, rsp_valid}, PADDR);
      end
      if (c == 2) begin PREADY = 1'b1; prdata_drv = 32'hDEAD_BEEF; end
      tick();
    end
    compared++;
    if ({rsp_valid, PSEL, rsp_err} !== 3'b100 || rsp_rdata !== 32'hDEAD_BEEF) begin
      mismatched++;
      $display("[TB] FAIL rd_resp: rv/sel/err got %b required 100, rdata %h required deadbeef",
               {rsp_valid, PSEL, rsp_err}, rsp_rdata);
    end
    prdata_drv = 32'h0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int n;
    PREADY = 1'b1; rsp_ready = 1'b0; prdata_auto = 1'b1;
    for (int k = 0; k < 5; k++) push_req(1'b0, 32'h100 + 32'(4 * k), 32'h0);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h114;
    compared++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_rdata !== 32'hA5A5_0100) begin
      mismatched++;
      $display("[TB] FAIL full_sixth: req_ready got %b required 0, rv %b required 1, rdata %h required a5a50100",
               req_ready, rsp_valid, rsp_rdata);
    end
    tick(); tick();
    compared++;
    if (req_ready !== 1'b0 || busy !== 1'b1 || rsp_rdata !== 32'hA5A5_0100) begin
      mismatched++;
      $display("[TB] FAIL full_hold: req_ready got %b required 0, busy %b required 1, rdata %h required a5a50100",
               req_ready, busy, rsp_rdata);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      n = 0;
      while (!rsp_valid && n < 20) begin tick(); n++; end
      compared++;
      if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== (32'hA5A5_0100 + 32'(4 * k))) begin
        mismatched++;
        $display("[TB] FAIL b2b_rsp%0d: rv %b err %b rdata %h, required 1 0 %h",
                 k, rsp_valid, rsp_err, rsp_rdata, 32'hA5A5_0100 + 32'(4 * k));
      end
      tick();
    end
    rsp_ready = 1'b0;
    tick();
    compared++;
    if ({busy, rsp_valid, PSEL} !== 3'b000) begin
      mismatched++; $display("[TB] FAIL b2b_drain: busy/rv/sel got %b required 000", {busy, rsp_valid, PSEL});
    end
  endtask

  task automatic test_slverr();
    int n;
    logic [31:0] exp_data [2];
    logic        exp_err  [2];
    exp_data[0] = 32'h0;         exp_err[0] = 1'b1;
    exp_data[1] = 32'hA5A5_0204; exp_err[1] = 1'b0;
    PREADY = 1'b1; rsp_ready = 1'b1; prdata_auto = 1'b1; slverr_on_write = 1'b1;
    push_req(1'b1, 32'h200, 32'h0000_0055);
    push_req(1'b0, 32'h204, 32'h0);
    for (int k = 0; k < 2; k++) begin
      n = 0;
      while (!rsp_valid && n < 20) begin tick(); n++; end
      compared++;
      if (rsp_valid !== 1'b1 || rsp_err !== exp_err[k] || rsp_rdata !== exp_data[k]) begin
        mismatched++;
        $display("[TB] FAIL slverr_rsp%0d: rv %b err %b rdata %h, required 1 %b %h",
                 k, rsp_valid, rsp_err, rsp_rdata, exp_err[k], exp_data[k]);
      end
      tick();
    end
    slverr_on_write = 1'b0;
    rsp_ready = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    int seen;
    PREADY = 1'b0; rsp_ready = 1'b0; prdata_auto = 1'b1;
    push_req(1'b0, 32'h300, 32'h0);
    push_req(1'b0, 32'h304, 32'h0);
    push_req(1'b0, 32'h308, 32'h0);
    compared++;
    if ({PSEL, PENABLE} !== 2'b11) begin
      mismatched++; $display("[TB] FAIL rst_pre_access: sel/en got %b required 11", {PSEL, PENABLE});
    end
    PRESET = 1'b1;
    tick();
    compared++;
    if ({PSEL, PENABLE, rsp_valid, req_ready, busy} !== 5'b00010) begin
      mismatched++;
      $display("[TB] FAIL rst_mid: sel/en/rv/rdy/busy got %b required 00010",
               {PSEL, PENABLE, rsp_valid, req_ready, busy});
    end
    PRESET = 1'b0; PREADY = 1'b1; rsp_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (rsp_valid || PSEL) seen++;
    end
    compared++;
    if (seen !== 0) begin
      mismatched++; $display("[TB] FAIL rst_no_rsp: activity cycles got %0d required 0", seen);
    end
    rsp_ready = 1'b0;
  endtask

`ifdef APB_TIMEOUT_EN
  task automatic test_timeout();
    PREADY = 1'b0; rsp_ready = 1'b0; prdata_auto = 1'b1;
    push_req(1'b0, 32'h400, 32'h0);
    tick(); tick();
    repeat (15) tick();
    compared++;
    if ({PSEL, PENABLE, rsp_valid} !== 3'b110) begin
      mismatched++; $display("[TB] FAIL tmo_before: sel/en/rv got %b required 110", {PSEL, PENABLE, rsp_valid});
    end
    tick();
    compared++;
    if ({PSEL, PENABLE, rsp_valid, rsp_err} !== 4'b0011 || rsp_rdata !== 32'h0) begin
      mismatched++;
      $display("[TB] FAIL tmo_abort: sel/en/rv/err got %b required 0011, rdata %h required 0",
               {PSEL, PENABLE, rsp_valid, rsp_err}, rsp_rdata);
    end
    PREADY = 1'b1; rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask
`else
  task automatic test_no_timeout();
    PREADY = 1'b0; rsp_ready = 1'b0; prdata_auto = 1'b1;
    push_req(1'b0, 32'h400, 32'h0);
    tick(); tick();
    repeat (20) tick();
    compared++;
    if ({PSEL, PENABLE, rsp_valid} !== 3'b110) begin
      mismatched++; $display("[TB] FAIL notmo_wait: sel/en/rv got %b required 110", {PSEL, PENABLE, rsp_valid});
    end
    PREADY = 1'b1;
    tick();
    compared++;
    if ({rsp_valid, rsp_err, PSEL} !== 3'b100 || rsp_rdata !== 32'hA5A5_0400) begin
      mismatched++;
      $display("[TB] FAIL notmo_resp: rv/err/sel got %b required 100, rdata %h required a5a50400",
               {rsp_valid, rsp_err, PSEL}, rsp_rdata);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask
`endif

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    PRESET = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b0; PREADY = 1'b0; prdata_auto = 1'b0; prdata_drv = '0; slverr_on_write = 1'b0;
    test_reset();
    test_write_basic();
    test_read_wait();
    test_back_to_back();
    test_slverr();
    test_reset_mid();
`ifdef APB_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
